// File: rtl/halfband_interp2.sv
// 2x interpolating halfband FIR (11-tap prototype, unity gain), one shared multiplier.
// Latency: first output 5 cycles after accept; 7 cycles per input with no backpressure.
// Backpressure: out_ready low holds EMIT_E/EMIT_O indefinitely; in_ready stays low until IDLE.
module halfband_interp2 #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 21,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam logic signed [COEF_W-1:0] C0 = COEF_W'(8336);
    localparam logic signed [COEF_W-1:0] C2 = COEF_W'(-57000);
    localparam logic signed [COEF_W-1:0] C4 = COEF_W'(310840);
    // x2 tap symmetry folded into the shift: Q1.20 product scaled by 2 -> shift by 19
    localparam int                       SHIFT    = COEF_W - 2;
    localparam logic signed [ACC_W-1:0]  RND_HALF = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX  = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN  = -SAT_MAX - ACC_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MAC    = 3'd1,
        RND    = 3'd2,
        EMIT_E = 3'd3,
        EMIT_O = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  d_q [6];
    logic signed [DATA_W-1:0]  d_d [6];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [1:0]                k_q, k_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;

    logic signed [DATA_W:0]        pair;
    logic signed [COEF_W-1:0]      coef;
    logic signed [DATA_W+COEF_W:0] prod;
    logic signed [ACC_W-1:0]       rnd_sum;
    logic signed [ACC_W-1:0]       scaled;
    logic [DATA_W-1:0]             sat_val;

    always_comb begin
        pair = '0;
        coef = '0;
        case (k_q)
            2'd0: begin
                pair = {d_q[0][DATA_W-1], d_q[0]} + {d_q[5][DATA_W-1], d_q[5]};
                coef = C0;
            end
            2'd1: begin
                pair = {d_q[1][DATA_W-1], d_q[1]} + {d_q[4][DATA_W-1], d_q[4]};
                coef = C2;
            end
            default: begin
                pair = {d_q[2][DATA_W-1], d_q[2]} + {d_q[3][DATA_W-1], d_q[3]};
                coef = C4;
            end
        endcase
        prod    = pair * coef;
        rnd_sum = acc_q + RND_HALF;
        scaled  = rnd_sum >>> SHIFT;
        if (scaled > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (scaled < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_val = scaled[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        acc_d       = acc_q;
        k_d         = k_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    d_d[0] = in_data;
                    for (int i = 1; i < 6; i++) begin
                        d_d[i] = d_q[i-1];
                    end
                    acc_d   = '0;
                    k_d     = 2'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (k_q == 2'd2) begin
                    state_d = RND;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            RND: begin
                out_data_d  = sat_val;
                out_valid_d = 1'b1;
                state_d     = EMIT_E;
            end
            EMIT_E: begin
                if (out_ready) begin
                    out_data_d = d_q[2];
                    state_d    = EMIT_O;
                end
            end
            EMIT_O: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < 6; i++) begin
                d_q[i] <= '0;
            end
            acc_q       <= '0;
            k_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = rst && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
